// File: rtl/wb_rsa_mw.sv
// Wishbone slave front-end for an external modular-exponentiation core.
// Operands are banked 32-bit words; one exponentiation is sequenced through IDLE/START/BUSY.
module wb_rsa_mw #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned E_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              irq_o,
  output logic              core_start,
  output logic [WIDTH-1:0]  core_m,
  output logic [WIDTH-1:0]  core_n,
  output logic [WIDTH-1:0]  core_ninv,
  output logic [WIDTH-1:0]  core_r2,
  output logic [E_BITS-1:0] core_e,
  input  logic [WIDTH-1:0]  core_c,
  input  logic              core_done
);

  localparam int unsigned NW = WIDTH / 32;
  localparam int unsigned NE = E_BITS / 32;
  localparam logic [31:0] PARAM_VAL = {E_BITS[15:0], WIDTH[15:0]};

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  m_reg, n_reg, ninv_reg, r2_reg, c_reg;
  logic [E_BITS-1:0] e_reg;
  logic              ctrl_auto, ctrl_ie, st_done, st_werr;
  logic              auto_nxt, ie_nxt, done_nxt, werr_nxt;
  logic [31:0]       cycles, busy_cnt, cnt_inc;
  logic [31:0]       rdata, m_rd, n_rd, ninv_rd, r2_rd, c_rd, e_rd;
  logic              acc, wr, idle, ctrl_wr, stat_wr, op_wr;
  logic              start_req, auto_req, trig, core_fin;
  logic [3:0]        bank;
  logic [5:0]        idx;
  logic [31:0]       wmask;
  logic [21:0]       unused_adr;

  assign unused_adr = {wb_adr_i[31:12], wb_adr_i[1:0]};

  assign acc   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr    = acc & wb_we_i;
  assign bank  = wb_adr_i[11:8];
  assign idx   = wb_adr_i[7:2];
  assign wmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign idle  = (state == S_IDLE);

  assign ctrl_wr   = wr && (bank == 4'h0) && (idx == 6'd0);
  assign stat_wr   = wr && (bank == 4'h0) && (idx == 6'd1);
  assign op_wr     = wr && (bank >= 4'h1) && (bank <= 4'h5);
  assign start_req = ctrl_wr & wb_sel_i[0] & wb_dat_i[0];
  assign auto_req  = wr && (bank == 4'h1) && (idx == 6'(NW - 1)) && ctrl_auto;
  assign trig      = start_req | auto_req;
  assign core_fin  = (state == S_BUSY) && core_done;
  assign cnt_inc   = (busy_cnt == '1) ? busy_cnt : busy_cnt + 32'd1;

  assign core_start = (state == S_START);
  assign core_m     = m_reg;
  assign core_n     = n_reg;
  assign core_ninv  = ninv_reg;
  assign core_r2    = r2_reg;
  assign core_e     = e_reg;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [31:0] mask);
    return (old & ~mask) | (dat & mask);
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trig) state_nxt = S_START;
      S_START: state_nxt = S_BUSY;
      S_BUSY:  if (core_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clears are applied before sets so a same-cycle set always wins.
  always_comb begin
    auto_nxt = ctrl_auto;
    ie_nxt   = ctrl_ie;
    if (ctrl_wr && wb_sel_i[0]) begin
      auto_nxt = wb_dat_i[1];
      ie_nxt   = wb_dat_i[2];
    end
    done_nxt = st_done;
    if (stat_wr && wb_sel_i[0] && wb_dat_i[1]) done_nxt = 1'b0;
    if (idle && trig) done_nxt = 1'b0;
    if (core_fin) done_nxt = 1'b1;
    werr_nxt = st_werr;
    if (stat_wr && wb_sel_i[0] && wb_dat_i[2]) werr_nxt = 1'b0;
    if (!idle && (trig || op_wr)) werr_nxt = 1'b1;
  end

  always_comb begin
    m_rd = '0; n_rd = '0; ninv_rd = '0; r2_rd = '0; c_rd = '0; e_rd = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (idx == 6'(i)) begin
        m_rd    = m_reg[i*32 +: 32];
        n_rd    = n_reg[i*32 +: 32];
        ninv_rd = ninv_reg[i*32 +: 32];
        r2_rd   = r2_reg[i*32 +: 32];
        c_rd    = c_reg[i*32 +: 32];
      end
    end
    for (int unsigned i = 0; i < NE; i++) begin
      if (idx == 6'(i)) e_rd = e_reg[i*32 +: 32];
    end
    rdata = '0;
    case (bank)
      4'h0: begin
        case (idx)
          6'd0:    rdata = {29'd0, ctrl_ie, ctrl_auto, 1'b0};
          6'd1:    rdata = {29'd0, st_werr, st_done, !idle};
          6'd2:    rdata = cycles;
          6'd3:    rdata = PARAM_VAL;
          default: rdata = '0;
        endcase
      end
      4'h1:    rdata = m_rd;
      4'h2:    rdata = e_rd;
      4'h3:    rdata = n_rd;
      4'h4:    rdata = ninv_rd;
      4'h5:    rdata = r2_rd;
      4'h6:    rdata = c_rd;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      st_done   <= 1'b0;
      st_werr   <= 1'b0;
      irq_o     <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      cycles    <= '0;
      busy_cnt  <= '0;
      c_reg     <= '0;
    end else begin
      state     <= state_nxt;
      ctrl_auto <= auto_nxt;
      ctrl_ie   <= ie_nxt;
      st_done   <= done_nxt;
      st_werr   <= werr_nxt;
      irq_o     <= done_nxt & ie_nxt;
      wb_ack_o  <= acc;
      wb_dat_o  <= (acc && !wb_we_i) ? rdata : '0;
      if (state == S_START) busy_cnt <= '0;
      else if (state == S_BUSY) busy_cnt <= cnt_inc;
      if (core_fin) begin
        cycles <= cnt_inc;
        c_reg  <= core_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg    <= '0;
      e_reg    <= '0;
      n_reg    <= '0;
      ninv_reg <= '0;
      r2_reg   <= '0;
    end else if (op_wr && idle) begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (idx == 6'(i)) begin
          case (bank)
            4'h1:    m_reg[i*32 +: 32]    <= merge(m_reg[i*32 +: 32], wb_dat_i, wmask);
            4'h3:    n_reg[i*32 +: 32]    <= merge(n_reg[i*32 +: 32], wb_dat_i, wmask);
            4'h4:    ninv_reg[i*32 +: 32] <= merge(ninv_reg[i*32 +: 32], wb_dat_i, wmask);
            4'h5:    r2_reg[i*32 +: 32]   <= merge(r2_reg[i*32 +: 32], wb_dat_i, wmask);
            default: ;
          endcase
        end
      end
      for (int unsigned i = 0; i < NE; i++) begin
        if (bank == 4'h2 && idx == 6'(i))
          e_reg[i*32 +: 32] <= merge(e_reg[i*32 +: 32], wb_dat_i, wmask);
      end
    end
  end

endmodule

// File: tb/tb_wb_rsa_mw.sv
// Randomised bench for wb_rsa_mw against a register-map level reference model and a model core.
module tb_wb_rsa_mw;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned E_BITS = 32;
  localparam int unsigned NW     = WIDTH / 32;
  localparam int unsigned NE     = E_BITS / 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]       wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]        wb_sel_i;
  logic              wb_ack_o, irq_o, core_start;
  logic [WIDTH-1:0]  core_m, core_n, core_ninv, core_r2;
  logic [E_BITS-1:0] core_e;
  logic [WIDTH-1:0]  core_c = '0;
  logic              core_done = 1'b0;

  wb_rsa_mw #(.WIDTH(WIDTH), .E_BITS(E_BITS)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .irq_o(irq_o),
    .core_start(core_start), .core_m(core_m), .core_n(core_n),
    .core_ninv(core_ninv), .core_r2(core_r2), .core_e(core_e),
    .core_c(core_c), .core_done(core_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc_cnt = 0, n_starts = 0, start_cyc = 0, last_acc_cyc = 0;
  int fin_cnt = 0, fin_seen = 0;
  int core_delay = 20;
  bit [WIDTH-1:0] core_val;
  bit irq_pre, irq_at_fin;

  // reference model state
  bit [31:0] mbank [7][64];
  bit        m_auto, m_ie, m_done, m_werr, m_busy;
  bit [31:0] m_cycles;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (core_start === 1'b1) begin
      n_starts  = n_starts + 1;
      start_cyc = cyc_cnt;
    end
  end

  // model core: done asserted during the core_delay-th BUSY cycle
  always begin
    @(posedge clk); #1;
    if (core_start === 1'b1) begin
      repeat (core_delay) @(posedge clk);
      #1;
      core_c    = core_val;
      core_done = 1'b1;
      irq_pre   = irq_o;
      @(posedge clk); #1;
      core_done  = 1'b0;
      irq_at_fin = irq_o;
      fin_cnt    = fin_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int unsigned lim(input bit [3:0] b);
    return (b == 4'h2) ? NE : NW;
  endfunction

  function automatic bit [31:0] addr(input int unsigned b, input int unsigned i);
    return 32'((b << 8) | (i << 2));
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] d, input bit [3:0] s);
    bit [31:0] r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    foreach (mbank[b, i]) mbank[b][i] = '0;
    m_auto = 0; m_ie = 0; m_done = 0; m_werr = 0; m_busy = 0; m_cycles = '0;
  endtask

  task automatic model_trigger();
    if (m_busy) m_werr = 1;
    else begin
      m_busy = 1;
      m_done = 0;
    end
  endtask

  task automatic model_write(input bit [31:0] a, input bit [3:0] s, input bit [31:0] d);
    bit [3:0] b = a[11:8];
    bit [5:0] i = a[7:2];
    if (b == 4'h0 && i == 6'd0 && s[0]) begin
      m_auto = d[1];
      m_ie   = d[2];
      if (d[0]) model_trigger();
    end else if (b == 4'h0 && i == 6'd1 && s[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_werr = 0;
    end else if (b >= 4'h1 && b <= 4'h5) begin
      if (m_busy) m_werr = 1;
      else if (32'(i) < lim(b)) mbank[b][i] = merge(mbank[b][i], d, s);
      if (b == 4'h1 && 32'(i) == NW - 1 && m_auto) model_trigger();
    end
  endtask

  function automatic bit [31:0] exp_read(input bit [31:0] a);
    bit [3:0] b = a[11:8];
    bit [5:0] i = a[7:2];
    if (b == 4'h0) begin
      case (i)
        6'd0:    return {29'd0, m_ie, m_auto, 1'b0};
        6'd1:    return {29'd0, m_werr, m_done, m_busy};
        6'd2:    return m_cycles;
        6'd3:    return 32'h0020_0040;
        default: return '0;
      endcase
    end
    if (b >= 4'h1 && b <= 4'h6 && 32'(i) < lim(b)) return mbank[b][i];
    return '0;
  endfunction

  task automatic bus(input bit we, input bit [31:0] a, input bit [3:0] s, input bit [31:0] d,
                     output bit [31:0] r);
    int n = 0;
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_sel_i = s; wb_dat_i = d;
    do begin
      @(posedge clk); #1;
      n++;
    end while (wb_ack_o !== 1'b1 && n < 8);
    last_acc_cyc = cyc_cnt;
    r = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    chk("ack_lat", n, 1);
  endtask

  task automatic wr(input bit [31:0] a, input bit [3:0] s, input bit [31:0] d);
    bit [31:0] r;
    bus(1'b1, a, s, d, r);
    model_write(a, s, d);
  endtask

  task automatic rd(input string tag, input bit [31:0] a);
    bit [31:0] r;
    bus(1'b0, a, 4'h0, 32'h0, r);
    chk(tag, r, exp_read(a));
  endtask

  task automatic wait_fin(output bit ok);
    int n = 0;
    while (fin_cnt == fin_seen && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (fin_cnt != fin_seen);
    fin_seen = fin_cnt;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    wait_fin(ok);
    chk({tag, "_done_seen"}, ok, 1'b1);
    if (ok) begin
      m_busy = 0; m_done = 1; m_cycles = 32'(core_delay);
      for (int unsigned i = 0; i < NW; i++) mbank[6][i] = core_val[i*32 +: 32];
      chk({tag, "_irq_pre"}, irq_pre, 1'b0);
      chk({tag, "_irq"}, irq_at_fin, m_ie);
    end
  endtask

  task automatic chk_core();
    for (int unsigned i = 0; i < NW; i++) begin
      chk("core_m", core_m[i*32 +: 32], mbank[1][i]);
      chk("core_n", core_n[i*32 +: 32], mbank[3][i]);
      chk("core_ninv", core_ninv[i*32 +: 32], mbank[4][i]);
      chk("core_r2", core_r2[i*32 +: 32], mbank[5][i]);
    end
    for (int unsigned i = 0; i < NE; i++) chk("core_e", core_e[i*32 +: 32], mbank[2][i]);
  endtask

  task automatic load_random(input bit rnd_sel);
    for (int unsigned b = 1; b <= 5; b++)
      for (int unsigned i = 0; i < lim(4'(b)); i++)
        wr(addr(b, i), rnd_sel ? 4'($urandom_range(1, 15)) : 4'hF, $urandom);
  endtask

  initial begin
    int ns0;
    bit ok, ie;
    bit [31:0] r;
    rst = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    core_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", wb_ack_o, 1'b0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_start", core_start, 1'b0);
    chk("rst_dat", wb_dat_o, 32'h0);
    rst = 0;
    rd("param", 32'h00C);
    rd("status_rst", 32'h004);
    rd("c0_rst", 32'h600);

    // manual start
    wr(addr(1, 0), 4'hF, 32'h1);
    wr(addr(1, 1), 4'hF, 32'h2);
    wr(addr(2, 0), 4'hF, 32'h0001_0001);
    for (int unsigned b = 3; b <= 5; b++)
      for (int unsigned i = 0; i < NW; i++) wr(addr(b, i), 4'hF, $urandom);
    chk_core();
    core_delay = 20;
    core_val   = 64'h1234_5678_9ABC_DEF0;
    ns0 = n_starts;
    wr(32'h000, 4'hF, 32'h1);
    @(negedge clk); #1;
    chk("man_start_cnt", n_starts, ns0 + 1);
    chk("man_start_lat", start_cyc, last_acc_cyc);
    rd("man_status_busy", 32'h004);
    wait_done("man");
    chk("man_start_once", n_starts, ns0 + 1);
    rd("man_status_done", 32'h004);
    rd("man_cycles", 32'h008);
    bus(1'b0, 32'h600, 4'h0, 32'h0, r);
    chk("man_c0", r, 32'h9ABC_DEF0);
    bus(1'b0, 32'h604, 4'h0, 32'h0, r);
    chk("man_c1", r, 32'h1234_5678);

    // AUTO start
    wr(32'h000, 4'hF, 32'h6);
    core_delay = $urandom_range(5, 30);
    core_val   = {$urandom, $urandom};
    ns0 = n_starts;
    wr(addr(1, 0), 4'hF, $urandom);
    @(negedge clk); #1;
    chk("auto_w0_nostart", n_starts, ns0);
    wr(addr(1, 1), 4'hF, $urandom);
    @(negedge clk); #1;
    chk("auto_start", n_starts, ns0 + 1);
    chk("auto_lat", start_cyc, last_acc_cyc);
    chk("auto_irq_clr", irq_o, 1'b0);
    wait_done("auto");
    wr(32'h004, 4'hF, 32'h2);
    chk("irq_w1c", irq_o, 1'b0);
    rd("auto_status", 32'h004);

    // busy protection
    wr(32'h000, 4'hF, 32'h0);
    wr(addr(3, 0), 4'hF, 32'h0BAD_F00D);
    core_delay = 40;
    ns0 = n_starts;
    wr(32'h000, 4'hF, 32'h1);
    wr(addr(3, 0), 4'hF, 32'hFFFF_FFFF);
    wr(32'h000, 4'hF, 32'h1);
    bus(1'b0, 32'h004, 4'h0, 32'h0, r);
    chk("prot_status", r, 32'h5);
    rd("prot_n0", addr(3, 0));
    wait_done("prot");
    chk("prot_starts", n_starts, ns0 + 1);
    wr(32'h004, 4'hF, 32'h4);
    bus(1'b0, 32'h004, 4'h0, 32'h0, r);
    chk("prot_werr_clr", r, 32'h2);

    // byte enables and out-of-range access
    wr(addr(2, 0), 4'hF, 32'h0);
    wr(addr(2, 0), 4'b0101, 32'hAABB_CCDD);
    bus(1'b0, addr(2, 0), 4'h0, 32'h0, r);
    chk("e0_sel", r, 32'h00BB_00DD);
    wr(addr(1, 5), 4'hF, $urandom);
    rd("m5_oor", addr(1, 5));
    wr(addr(2, 1), 4'hF, $urandom);
    rd("e1_oor", addr(2, 1));
    wr(32'h010, 4'hF, $urandom);
    rd("unmapped_010", 32'h010);
    rd("unmapped_700", 32'h700);
    chk_core();

    // randomised operations
    repeat (6) begin
      wr(32'h000, 4'hF, 32'h0);
      load_random(1'b1);
      repeat (3) begin
        int unsigned b = $urandom_range(1, 5);
        rd("rnd_rb", addr(b, $urandom_range(0, lim(4'(b)) - 1)));
      end
      chk_core();
      core_delay = $urandom_range(1, 40);
      core_val   = {$urandom, $urandom};
      ie = 1'($urandom_range(0, 1));
      ns0 = n_starts;
      if ($urandom_range(0, 1) == 1) begin
        wr(32'h000, 4'hF, {29'd0, ie, 1'b1, 1'b0});
        wr(addr(1, NW - 1), 4'hF, $urandom);
      end else begin
        wr(32'h000, 4'hF, {29'd0, ie, 1'b0, 1'b0});
        wr(32'h000, 4'hF, {29'd0, ie, 1'b0, 1'b1});
      end
      wait_done("rnd");
      chk("rnd_starts", n_starts, ns0 + 1);
      rd("rnd_status", 32'h004);
      rd("rnd_cycles", 32'h008);
      for (int unsigned i = 0; i < NW; i++) rd("rnd_c", addr(6, i));
      wr(32'h004, 4'hF, 32'h6);
      rd("rnd_status_clr", 32'h004);
    end

    // reset in the middle of an operation; the late core_done must be ignored
    core_delay = 60;
    core_val   = {$urandom, $urandom};
    wr(32'h000, 4'hF, 32'h5);
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    chk("rstmid_irq", irq_o, 1'b0);
    rst = 0;
    wait_fin(ok);
    chk("rstmid_core_done_seen", ok, 1'b1);
    @(posedge clk); #1;
    chk("rstmid_irq_after", irq_o, 1'b0);
    rd("rstmid_status", 32'h004);
    rd("rstmid_c0", 32'h600);
    rd("rstmid_cycles", 32'h008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rsa_mw.md
# wb_rsa_mw

Parametrised Wishbone slave front-end for the modular-exponentiation (RSA) core, for operands wider than the 32-bit bus. Operands are loaded word-by-word into banked registers. The block sequences one exponentiation through an explicit start/busy/done state machine and latches the result. It also reports status, cycle count and an interrupt to the RV32I CPU. It sits between the CPU data bus and the core; the core is external and attaches through the `core_*` ports.

## Interface
Parameters:
- WIDTH, 64: modulus/message/result width in bits; multiple of 32, 32..2048; NW = WIDTH/32 words.
- E_BITS, 32: exponent width in bits; multiple of 32, 32..2048; NE = E_BITS/32 words.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_cyc_i, wb_stb_i  in  1  Wishbone cycle/strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  32  byte address; bits [11:2] decoded.
- wb_sel_i  in  4  byte enables for writes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid with ack.
- wb_ack_o  out  1  single-cycle acknowledge.
- irq_o  out  1  registered interrupt = DONE & IE.
- core_start  out  1  one-cycle start pulse to core.
- core_m, core_n, core_ninv, core_r2  out  WIDTH  operand registers, driven continuously.
- core_e  out  E_BITS  exponent register.
- core_c  in  WIDTH  core result.
- core_done  in  1  core completion.

## Operation
- Register map (byte offsets):
  - 0x000 CTRL: bit0 START (write-1 pulse, reads 0), bit1 AUTO, bit2 IE.
  - 0x004 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 WERR (sticky, W1C).
  - 0x008 CYCLES (RO).
  - 0x00C PARAM (RO) = {E_BITS[15:0], WIDTH[15:0]}.
- Operand banks of 64 words each, word i at base+4i, word 0 least significant:
  - M 0x100, E 0x200, N 0x300, N_INV 0x400, R2 0x500: R/W.
  - C 0x600: RO, returns the latched result.
- Bank index ≥ NW (≥ NE for E): read 0, write ignored. Unmapped addresses: read 0, write ignored, still acked.
- Writes honour wb_sel_i per byte on all writable registers. W1C bits clear only where the byte is enabled and the bit is 1.
- FSM states and transitions:
  - IDLE→START on CTRL.START=1 write.
  - IDLE→START on a write to M word NW-1 while AUTO=1.
  - START→BUSY unconditionally after 1 cycle. core_start=1 only in START.
  - BUSY→IDLE when core_done=1. On this transition: latch core_c into the result register, set DONE, load CYCLES.
- core_done is ignored outside BUSY.
- Entering START clears DONE.
- START or AUTO trigger while not IDLE is ignored and sets WERR.
- Operand-bank writes while in START/BUSY are ignored, acked, and set WERR.
- CYCLES counts the BUSY cycles of the last operation, including the done cycle, and saturates at 0xFFFFFFFF. It holds its value until the next completion.

## Timing
- Access accepted at cycle T when cyc&stb&!ack. ack=1 at T+1 only, with wb_dat_o valid. The next access can be accepted at T+2 (no back-to-back acks).
- Write takes effect at T+1.
- Start write accepted at T: START state and core_start=1 at T+1, BUSY from T+2. STATUS.BUSY reads 1 from T+1 (START counts as busy).
- core_done high at cycle D in BUSY:
  - At D+1: IDLE, DONE=1, result valid, CYCLES updated.
  - irq_o=1 at D+1 if IE=1.
- Same-cycle DONE set and W1C of DONE: set wins.
- WERR set and W1C in the same cycle: set wins.
- Reset values (asynchronous, immediate): all operand and result registers 0; CTRL 0; STATUS 0; CYCLES 0; FSM IDLE; wb_ack_o 0; wb_dat_o 0; core_start 0; irq_o 0.
- Reset mid-operation returns to IDLE. A later core_done is ignored until the next start.

## Test plan
- **Reset read-back.** Assert rst, then read PARAM, STATUS, C word 0 with WIDTH=64, E_BITS=32. Required: 0x00200040, 0x0, 0x0. ack arrives exactly 1 cycle after strobe.
- **Manual start.** Load M=0x0000000200000001, E=0x10001 and N/N_INV/R2. Write CTRL=1.
  - core_start is high for exactly 1 cycle, 1 cycle after the write.
  - Model core asserts done after 20 BUSY cycles with core_c=0x1234_5678_9ABC_DEF0.
  - Required: DONE=1; CYCLES=20; C words read 0x9ABCDEF0, 0x12345678.
- **AUTO start.** Write CTRL=0x6, then M word 0, then M word 1. Required: START follows the word-1 write only. irq_o rises 1 cycle after core_done.
- **Busy protection.** While BUSY, write N word 0=0xFFFFFFFF, then write CTRL=1.
  - Required: N unchanged; exactly one core_start total; STATUS reads 0x5.
  - Writing STATUS=0x4 clears WERR only.
- **Byte enables and out-of-range access.**
  - Write E word 0=0xAABBCCDD with sel=0b0101 over 0x0. Required read: 0x00BB00DD.
  - Write M word 5 (index ≥ NW). Required: read returns 0, acked.
- **Reset mid-operation.** Assert rst during BUSY, then pulse core_done. Required: DONE stays 0, irq_o stays 0, C reads 0.
